// File: rtl/seg7_scan_driver_if.sv
// Digit data in, multiplexed segment/enable pins out, for the 4-digit scan driver.
// master is the digit source side, slave is the scan driver itself.
interface seg7_scan_driver_if;
    logic [3:0] Hex_0;
    logic [3:0] Hex_1;
    logic [3:0] Hex_2;
    logic [3:0] Hex_3;
    logic [3:0] dp_mask;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig_en;

    modport master (
        output Hex_0, Hex_1, Hex_2, Hex_3, dp_mask,
        input  seg, dp, dig_en
    );

    modport slave (
        input  Hex_0, Hex_1, Hex_2, Hex_3, dp_mask,
        output seg, dp, dig_en
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver: frame-aligned snapshot, BCD decode,
// leading-zero blanking and a guard interval at the start of every digit slot.
module seg7_scan_driver #(
    parameter int IN_CLK_HZ  = 50_000_000,
    parameter int SCAN_HZ    = 1000,
    parameter int GUARD      = 16,
    parameter bit BLANK_LEAD = 1'b1,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_driver_if.slave bus
);
    localparam int            SLOT      = IN_CLK_HZ / SCAN_HZ;
    localparam int            CW        = (SLOT > 2) ? $clog2(SLOT) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
    localparam logic [6:0]    SEG_POL   = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic          DP_POL    = ACTIVE_LOW;
    localparam logic [3:0]    EN_POL    = ACTIVE_LOW ? 4'hF : 4'h0;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   snap_hex;
    logic [3:0]    snap_dp;

    logic          frame_end;
    logic [3:0]    cur_digit;
    logic          z3, z2, z1;
    logic          blank;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic [3:0]    en_nxt;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    assign frame_end = (cnt == CNT_LAST) && (idx == 2'd3);
    assign z3        = (snap_hex[15:12] == 4'd0);
    assign z2        = (snap_hex[11:8]  == 4'd0);
    assign z1        = (snap_hex[7:4]   == 4'd0);

    always_comb begin
        cur_digit = snap_hex[{idx, 2'b00} +: 4];
        blank     = 1'b0;
        if (BLANK_LEAD) begin
            case (idx)
                2'd3:    blank = z3;
                2'd2:    blank = z3 && z2;
                2'd1:    blank = z3 && z2 && z1;
                default: blank = 1'b0;
            endcase
        end

        seg_nxt = 7'h00;
        dp_nxt  = 1'b0;
        en_nxt  = 4'b0000;
        if (cnt >= CNT_GUARD) begin
            en_nxt  = 4'b0001 << idx;
            seg_nxt = blank ? 7'h00 : bcd_to_seg(cur_digit);
            dp_nxt  = snap_dp[idx];
        end
    end

    // Outputs are built from this cycle's cnt/idx/snapshot, so they lag by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= 2'd0;
            snap_hex   <= 16'h0000;
            snap_dp    <= 4'h0;
            bus.seg    <= SEG_POL;
            bus.dp     <= DP_POL;
            bus.dig_en <= EN_POL;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (frame_end) begin
                snap_hex <= {bus.Hex_3, bus.Hex_2, bus.Hex_1, bus.Hex_0};
                snap_dp  <= bus.dp_mask;
            end

            bus.seg    <= seg_nxt ^ SEG_POL;
            bus.dp     <= dp_nxt ^ DP_POL;
            bus.dig_en <= en_nxt ^ EN_POL;
        end
    end
endmodule
